uart_tx_arbiter: RTL and testbench

Shares one `uart` transmitter between `NUM_REQ` on-chip requesters. It sits between the requesters (loopback logic, status reporters, debug dumpers) and the `uart` TX inputs (`tx_data_i`, `tx_trigger_i`, `tx_complete_o`). Arbitration is round-robin with packet locking: once a requester starts a multi-byte packet, it keeps the transmitter until its `last` byte has gone out. The block sequences each byte through trigger, busy-wait and done-wait, with a timeout guard.

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter.
// Each byte runs trigger -> wait for busy -> wait for done, with a busy timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o,
    output logic                   timeout_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_trigger_o,
    input  logic                   tx_complete_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state, state_nx;
    logic [IW-1:0]      ptr, ptr_nx;
    logic               locked, locked_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [NUM_REQ-1:0] ready, ready_nx;
    logic [NUM_REQ-1:0] grant, grant_nx;
    logic [7:0]         data, data_nx;
    logic               trigger, trigger_nx;
    logic               timeout, timeout_nx;

    logic               found;
    logic [IW-1:0]      win;
    logic [IW-1:0]      idx;

    // A locked packet owner is the only candidate; otherwise search from ptr+1.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        if (locked) begin
            found = req_valid_i[ptr];
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                idx = IW'((int'(ptr) + i) % NUM_REQ);
                if (!found && req_valid_i[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
    end

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        locked_nx  = locked;
        cnt_nx     = cnt;
        ready_nx   = '0;
        grant_nx   = grant;
        data_nx    = data;
        trigger_nx = 1'b0;
        timeout_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_complete_i && found) begin
                    state_nx   = WAIT_BUSY;
                    data_nx    = req_data_i[8*win +: 8];
                    trigger_nx = 1'b1;
                    ready_nx   = NUM_REQ'(1) << win;
                    grant_nx   = NUM_REQ'(1) << win;
                    ptr_nx     = win;
                    locked_nx  = !req_last_i[win];
                    cnt_nx     = '0;
                end
            end
            WAIT_BUSY: begin
                if (!tx_complete_i) begin
                    state_nx = WAIT_DONE;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    state_nx   = WAIT_DONE;
                    timeout_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_complete_i) begin
                    state_nx = IDLE;
                    if (!locked) begin
                        grant_nx = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            ptr     <= IW'(NUM_REQ - 1);
            locked  <= 1'b0;
            cnt     <= '0;
            ready   <= '0;
            grant   <= '0;
            data    <= '0;
            trigger <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            locked  <= locked_nx;
            cnt     <= cnt_nx;
            ready   <= ready_nx;
            grant   <= grant_nx;
            data    <= data_nx;
            trigger <= trigger_nx;
            timeout <= timeout_nx;
        end
    end

    assign req_ready_o  = ready;
    assign grant_o      = grant;
    assign busy_o       = (state != IDLE) || locked;
    assign timeout_o    = timeout;
    assign tx_data_o    = data;
    assign tx_trigger_o = trigger;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a mock UART and a
// round-robin/packet-lock reference model for random traffic.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NREQ-1:0]   req_valid_i = '0;
    logic [8*NREQ-1:0] req_data_i = '0;
    logic [NREQ-1:0]   req_last_i = '0;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ-1:0]   grant_o;
    logic              busy_o;
    logic              timeout_o;
    logic [7:0]        tx_data_o;
    logic              tx_trigger_o;
    logic              tx_complete_i;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .BUSY_TIMEOUT(16)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_data_i(req_data_i),
        .req_last_i(req_last_i),
        .req_ready_o(req_ready_o),
        .grant_o(grant_o),
        .busy_o(busy_o),
        .timeout_o(timeout_o),
        .tx_data_o(tx_data_o),
        .tx_trigger_o(tx_trigger_o),
        .tx_complete_i(tx_complete_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Mock UART: mode 0 drops complete 2 cycles after a trigger and raises
    // it 20 cycles later; mode 1 never drops; mode 2 is driven by hand.
    int   mode = 0;
    int   mcnt = 0;
    logic mock_complete = 1'b1;
    logic man_complete = 1'b1;
    assign tx_complete_i = (mode == 2) ? man_complete : mock_complete;

    always @(negedge clk_i) begin
        if (mode != 0) begin
            mcnt = 0;
            mock_complete = 1'b1;
        end else if (tx_trigger_o) begin
            mcnt = 1;
        end else if (mcnt != 0) begin
            mcnt++;
            if (mcnt == 2) mock_complete = 1'b0;
            if (mcnt == 22) begin
                mock_complete = 1'b1;
                mcnt = 0;
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int last_trig = 0;

    logic [7:0] qd [NREQ][64];
    logic       ql [NREQ][64];
    int         qh [NREQ];
    int         qt [NREQ];

    int         ew [$];
    logic [7:0] ed [$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            if (qh[k] < qt[k]) begin
                req_valid_i[k]        = 1'b1;
                req_data_i[8*k +: 8]  = qd[k][qh[k]];
                req_last_i[k]         = ql[k][qh[k]];
            end else begin
                req_valid_i[k]        = 1'b0;
                req_data_i[8*k +: 8]  = 8'h00;
                req_last_i[k]         = 1'b0;
            end
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        qd[k][qt[k]] = d;
        ql[k][qt[k]] = l;
        qt[k]++;
    endtask

    // Waits for a trigger and checks the accepted byte, then the requester
    // advances to its next byte.
    task automatic expect_byte(input int w, input logic [7:0] d,
                               input int budget, input bit gap_chk,
                               input int hold);
        int n;
        bit seen;
        bit bad;
        n = 0;
        seen = 0;
        bad = 0;
        while (!seen && n < budget) begin
            @(negedge clk_i);
            n++;
            if (hold >= 0 && grant_o !== NREQ'(hold)) bad = 1;
            if (tx_trigger_o === 1'b1) seen = 1;
        end
        check("trigger_seen", 32'(seen), 1);
        if (hold >= 0) check("grant_hold", 32'(bad), 0);
        if (seen) begin
            check("tx_data", 32'(tx_data_o), 32'(d));
            check("ready", 32'(req_ready_o), 32'(1) << w);
            check("grant", 32'(grant_o), 32'(1) << w);
            if (gap_chk) check("trigger_gap", cyc - last_trig, 23);
            last_trig = cyc;
            qh[w]++;
            drive();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(busy_o === 1'b0 && tx_complete_i === 1'b1) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("reach_idle", 32'(busy_o === 1'b0), 1);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Expected order from the arbitration rules, assuming every requester
    // with bytes left is valid whenever the arbiter picks.
    task automatic build_model();
        int eh [NREQ];
        int left;
        int rp;
        int w;
        int k;
        bit rl;
        left = 0;
        for (int i = 0; i < NREQ; i++) begin
            eh[i] = qh[i];
            left += qt[i] - qh[i];
        end
        rp = NREQ - 1;
        rl = 0;
        ew.delete();
        ed.delete();
        while (left > 0) begin
            w = -1;
            if (rl) begin
                w = rp;
            end else begin
                for (int i = 1; i <= NREQ; i++) begin
                    k = (rp + i) % NREQ;
                    if (w < 0 && eh[k] < qt[k]) w = k;
                end
            end
            ew.push_back(w);
            ed.push_back(qd[w][eh[w]]);
            rl = !ql[w][eh[w]];
            rp = w;
            eh[w]++;
            left--;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int n;
        int c;
        int nb;
        bit bad;

        for (int k = 0; k < NREQ; k++) begin
            qh[k] = 0;
            qt[k] = 0;
        end
        repeat (2) @(negedge clk_i);
        check("rst_trigger", 32'(tx_trigger_o), 0);
        check("rst_ready", 32'(req_ready_o), 0);
        check("rst_grant", 32'(grant_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        check("rst_data", 32'(tx_data_o), 0);
        rst_i = 1'b0;

        // Single byte from requester 0.
        push(0, 8'hA5, 1'b1);
        drive();
        expect_byte(0, 8'hA5, 10, 0, -1);
        t0 = last_trig;
        @(negedge clk_i);
        check("trigger_width", 32'(tx_trigger_o), 0);
        check("ready_width", 32'(req_ready_o), 0);
        n = 0;
        while (grant_o !== 4'b0000 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check("grant_clear_cycle", cyc - t0, 22);
        wait_idle();

        // Four requesters, two rounds, fresh pointer.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NREQ; k++) push(k, 8'(8'h10 + k), 1'b1);
        drive();
        for (int i = 0; i < 8; i++)
            expect_byte(i % NREQ, 8'(8'h10 + i % NREQ), 40, i > 0, -1);
        wait_idle();

        // Locked 3-byte packet ahead of a competing requester.
        push(1, 8'h31, 1'b0);
        push(1, 8'h32, 1'b0);
        push(1, 8'h33, 1'b1);
        push(2, 8'h42, 1'b1);
        drive();
        expect_byte(1, 8'h31, 10, 0, -1);
        expect_byte(1, 8'h32, 40, 1, 2);
        expect_byte(1, 8'h33, 40, 1, 2);
        expect_byte(2, 8'h42, 40, 1, -1);
        wait_idle();

        // Busy-wait timeout.
        mode = 1;
        push(0, 8'h55, 1'b1);
        drive();
        expect_byte(0, 8'h55, 10, 0, -1);
        t0 = last_trig;
        n = 0;
        while (timeout_o !== 1'b1 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check("timeout_cycle", cyc - t0, 16);
        @(negedge clk_i);
        check("timeout_width", 32'(timeout_o), 0);
        mode = 0;
        push(1, 8'h66, 1'b1);
        drive();
        expect_byte(1, 8'h66, 20, 0, -1);
        wait_idle();

        // UART busy while a request waits in IDLE.
        mode = 2;
        man_complete = 1'b0;
        push(2, 8'h77, 1'b1);
        drive();
        bad = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (tx_trigger_o !== 1'b0 || busy_o !== 1'b0) bad = 1;
        end
        check("no_trigger_while_busy", 32'(bad), 0);
        man_complete = 1'b1;
        c = cyc;
        expect_byte(2, 8'h77, 1, 0, -1);
        check("trigger_after_rise", last_trig - c, 1);
        man_complete = 1'b0;
        repeat (3) @(negedge clk_i);
        man_complete = 1'b1;
        mode = 0;
        wait_idle();

        // Reset while requester 3 holds the lock mid-byte.
        push(3, 8'h81, 1'b0);
        push(3, 8'h82, 1'b1);
        drive();
        expect_byte(3, 8'h81, 10, 0, -1);
        repeat (5) @(negedge clk_i);
        check("locked_busy", 32'(busy_o), 1);
        check("locked_grant", 32'(grant_o), 32'h8);
        mode = 2;
        man_complete = 1'b0;
        rst_i = 1'b1;
        push(0, 8'h90, 1'b1);
        drive();
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midbyte_rst_outputs",
              {tx_trigger_o, req_ready_o, grant_o, busy_o, timeout_o, tx_data_o},
              0);
        bad = 0;
        repeat (9) begin
            @(negedge clk_i);
            if (tx_trigger_o !== 1'b0) bad = 1;
        end
        check("no_trigger_after_rst", 32'(bad), 0);
        man_complete = 1'b1;
        c = cyc;
        expect_byte(0, 8'h90, 1, 0, -1);
        check("rst_trigger_after_rise", last_trig - c, 1);
        man_complete = 1'b0;
        repeat (2) @(negedge clk_i);
        mode = 0;
        expect_byte(3, 8'h82, 40, 0, -1);
        wait_idle();

        // Random packets against the reference model.
        do_reset();
        for (int k = 0; k < NREQ; k++) begin
            qh[k] = 0;
            qt[k] = 0;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++)
                push(k, 8'($urandom), (b == nb - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        build_model();
        drive();
        for (int i = 0; i < ew.size(); i++)
            expect_byte(ew[i], ed[i], 60, i > 0, -1);
        wait_idle();
        check("final_grant", 32'(grant_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
